// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtract-based GCD engine.
package gcd_pkg;

   localparam int GCD_WIDTH = 4;

   typedef enum logic [1:0] {
      GCD_IDLE = 2'd0,
      GCD_RUN  = 2'd1,
      GCD_DONE = 2'd2
   } gcd_state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for gcd_core: sequences IDLE -> RUN -> DONE and decodes both handshakes.
module gcd_ctrl
   import gcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       out_ready,
   input  logic       run_stop,
   output logic       in_ready,
   output logic       out_valid,
   output logic       load,
   output gcd_state_t state
);

   gcd_state_t state_q;
   gcd_state_t state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GCD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and a result is held stable until it is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GCD_IDLE: if (in_valid)  state_d = GCD_RUN;
         GCD_RUN:  if (run_stop)  state_d = GCD_DONE;
         GCD_DONE: if (out_ready) state_d = GCD_IDLE;
         default:                 state_d = GCD_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == GCD_IDLE);
      out_valid = (state_q == GCD_DONE);
      load      = (state_q == GCD_IDLE) && in_valid;
      state     = state_q;
   end

endmodule

// File: rtl/substractor.sv
// 4-bit two's-complement subtractor stage: y = a + ~b + 1.
module substractor (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);

   assign y = a + ~b + 4'd1;

endmodule

// File: rtl/gcd_core.sv
// Sequential GCD engine: the larger operand is replaced by |A-B| each cycle until one is zero or both match.
module gcd_core
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic [WIDTH-1:0] out_iters
);

   logic [WIDTH-1:0] ra, rb, iters, res;
   logic [WIDTH-1:0] sub_a, sub_b, diff;
   logic [WIDTH:0]   cmp_sum;
   logic             a_ge_b, a_eq_b, any_zero, run_stop, load;
   gcd_state_t       state;

   gcd_ctrl u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .run_stop  (run_stop),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .load      (load),
      .state     (state)
   );

   // Carry-out of ra + ~rb + 1 is the ra >= rb flag; a zero low part then means equality.
   assign cmp_sum  = {1'b0, ra} + {1'b0, ~rb} + {{WIDTH{1'b0}}, 1'b1};
   assign a_ge_b   = cmp_sum[WIDTH];
   assign a_eq_b   = a_ge_b && (cmp_sum[WIDTH-1:0] == '0);
   assign any_zero = (ra == '0) || (rb == '0);
   assign run_stop = any_zero || a_eq_b;

   assign sub_a = a_ge_b ? ra : rb;
   assign sub_b = a_ge_b ? rb : ra;

   generate
      if (WIDTH == 4) begin : g_sub4
         substractor u_sub (
            .a (sub_a),
            .b (sub_b),
            .y (diff)
         );
      end else begin : g_subn
         assign diff = sub_a + ~sub_b + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra    <= '0;
         rb    <= '0;
         iters <= '0;
         res   <= '0;
      end else if (load) begin
         ra    <= in_a;
         rb    <= in_b;
         iters <= '0;
      end else if (state == GCD_RUN) begin
         if (any_zero) begin
            res <= ra | rb;
         end else if (a_eq_b) begin
            res <= ra;
         end else begin
            if (a_ge_b) ra <= diff;
            else        rb <= diff;
            iters <= iters + {{(WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   assign out_gcd   = res;
   assign out_iters = iters;

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed scenarios plus an exhaustive 16x16 sweep against a reference model.
module tb_gcd_core;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_gcd;
   logic [W-1:0] out_iters;

   logic [2*W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   gcd_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gcd   (out_gcd),
      .out_iters (out_iters)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // gcd by remainder Euclid; iteration count by counting subtractions
   function automatic logic [2*W-1:0] model(input int a, input int b);
      int x = a, y = b, t, n = 0;
      while (y != 0) begin t = x % y; x = y; y = t; end
      t = x;
      x = a; y = b;
      while (x != 0 && y != 0 && x != y) begin
         if (x > y) x = x - y; else y = y - x;
         n++;
      end
      return {t[W-1:0], n[W-1:0]};
   endfunction

   // Drives one operand pair through the input handshake and records the expected result.
   task automatic send(input int a, input int b);
      int guard = 0;
      while (!in_ready && guard < 100) begin tick(); guard++; end
      in_a = a[W-1:0];
      in_b = b[W-1:0];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_q.push_back(model(a, b));
   endtask

   // Cycles from now until out_valid; -1 if it never rises.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_gcd !== '0 || out_iters !== '0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b gcd=%0d iters=%0d, want 1 0 0 0",
                  in_ready, out_valid, out_gcd, out_iters);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      logic seen = 1'b0;
      send(12, 8);
      tick();
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_async: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_result: out_valid seen=%b, want 0", seen);
      end
   endtask

   task automatic test_basic(input int a, input int b, input int exp_lat, input int hold);
      int lat;
      logic [2*W-1:0] exp;
      send(a, b);
      wait_out(lat);
      checks++;
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL latency(%0d,%0d): got %0d, want %0d", a, b, lat, exp_lat);
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || {out_gcd, out_iters} !== exp_q[0]) begin
            errors++;
            $display("FAIL hold(%0d,%0d) cycle %0d: valid=%b gcd=%0d iters=%0d, want 1 %0d %0d",
                     a, b, i, out_valid, out_gcd, out_iters, exp_q[0][2*W-1:W], exp_q[0][W-1:0]);
         end
      end
      exp = exp_q.pop_front();
      checks++;
      if ({out_gcd, out_iters} !== exp) begin
         errors++;
         $display("FAIL result(%0d,%0d): gcd=%0d iters=%0d, want %0d %0d",
                  a, b, out_gcd, out_iters, exp[2*W-1:W], exp[W-1:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release(%0d,%0d): out_valid=%b in_ready=%b, want 0 1", a, b, out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [2*W-1:0] exp;
      in_a = 4'd6; in_b = 4'd4; in_valid = 1'b1;
      tick();
      exp_q.push_back(model(6, 4));
      in_a = W'($urandom_range(0, 15)); in_b = W'($urandom_range(0, 15));
      wait_out(lat);
      in_a = 4'd9; in_b = 4'd3;
      exp = exp_q.pop_front();
      checks++;
      if (lat !== 3 || {out_gcd, out_iters} !== exp) begin
         errors++;
         $display("FAIL b2b_first: lat=%0d gcd=%0d iters=%0d, want 3 %0d %0d",
                  lat, out_gcd, out_iters, exp[2*W-1:W], exp[W-1:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: in_ready=%b, want 1", in_ready);
      end
      tick();
      exp_q.push_back(model(9, 3));
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
      end
      wait_out(lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== 3 || {out_gcd, out_iters} !== exp) begin
         errors++;
         $display("FAIL b2b_second: lat=%0d gcd=%0d iters=%0d, want 3 %0d %0d",
                  lat, out_gcd, out_iters, exp[2*W-1:W], exp[W-1:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_exhaustive();
      int handshakes = 0;
      int bad = 0;
      logic [2*W-1:0] exp;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            int guard = 0;
            logic done = 1'b0;
            send(a, b);
            while (!done && guard < 200) begin
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  exp = exp_q.pop_front();
                  checks++;
                  if ({out_gcd, out_iters} !== exp) begin
                     errors++;
                     bad++;
                     if (bad < 10)
                        $display("FAIL sweep(%0d,%0d): gcd=%0d iters=%0d, want %0d %0d",
                                 a, b, out_gcd, out_iters, exp[2*W-1:W], exp[W-1:0]);
                  end
                  handshakes++;
                  done = 1'b1;
               end
               tick();
               guard++;
            end
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL sweep_dup(%0d,%0d): out_valid=%b after handshake, want 0", a, b, out_valid);
            end
         end
      end
      checks++;
      if (handshakes !== 256 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL sweep_count: handshakes=%0d pending=%0d, want 256 0", handshakes, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_basic(12, 8, 3, 5);
      test_basic(15, 1, 15, 0);
      test_basic(0, 9, 1, 0);
      test_basic(0, 0, 1, 0);
      test_basic(7, 7, 1, 0);
      test_back_to_back();
      test_exhaustive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
